// File: rtl/voice_alloc_pkg.sv
// Shared types and widths for the polyphonic voice allocator.
// Covers the FSM state encoding, note/velocity widths and the voice-index width helper.
package voice_alloc_pkg;

  localparam int NOTE_W = 7;
  localparam int VEL_W  = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    COMMIT  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Index width is never below one bit, so a two-voice build still has a legal vector.
  function automatic int vidx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/voice_slot.sv
// One voice slot. It holds the gate, note, velocity, age and sustained flag for one voice,
// and registers the retrigger pulse. It reacts only to strobes issued by the allocator.
module voice_slot
  import voice_alloc_pkg::*;
#(
  parameter int AGE_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic              vel_upd_i,
  input  logic              age_clr_i,
  input  logic              age_inc_i,
  input  logic              rpt_i,
  input  logic              rel_i,
  input  logic              sus_set_i,
  input  logic              sus_rel_i,
  input  logic [NOTE_W-1:0] note_i,
  input  logic [VEL_W-1:0]  vel_i,
  output logic              gate_o,
  output logic [NOTE_W-1:0] note_o,
  output logic [VEL_W-1:0]  vel_o,
  output logic [AGE_W-1:0]  age_o,
  output logic              rpt_o
);

  logic              gate_q;
  logic [NOTE_W-1:0] note_q;
  logic [VEL_W-1:0]  vel_q;
  logic [AGE_W-1:0]  age_q;
  logic              sus_q;
  logic              rpt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate_q <= 1'b0;
      note_q <= '0;
      vel_q  <= '0;
      age_q  <= '0;
      sus_q  <= 1'b0;
      rpt_q  <= 1'b0;
    end else begin
      rpt_q <= rpt_i;
      if (load_i) begin
        gate_q <= 1'b1;
        note_q <= note_i;
        vel_q  <= vel_i;
        sus_q  <= 1'b0;
      end else if (vel_upd_i) begin
        vel_q <= vel_i;
        sus_q <= 1'b0;
      end else if (rel_i) begin
        gate_q <= 1'b0;
        sus_q  <= 1'b0;
      end else if (sus_set_i) begin
        sus_q <= 1'b1;
      end else if (sus_rel_i && sus_q) begin
        gate_q <= 1'b0;
        sus_q  <= 1'b0;
      end
      // Only held voices age; a free voice keeps its age frozen.
      if (age_clr_i) age_q <= '0;
      else if (age_inc_i && gate_q && (age_q != '1)) age_q <= age_q + 1'b1;
    end
  end

  assign gate_o = gate_q;
  assign note_o = note_q;
  assign vel_o  = vel_q;
  assign age_o  = age_q;
  assign rpt_o  = rpt_q;

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: takes note events, scans the voice slots one per cycle, then commits a
// retrigger, a free-slot allocation, an oldest-voice steal or a release. Optional macro: VOICE_SUSTAIN_EN.
module voice_allocator
  import voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_note_on,
  input  logic [NOTE_W-1:0]            ev_note,
  input  logic [VEL_W-1:0]             ev_vel,
  output logic [NUM_VOICES-1:0]        voice_note_on,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [VEL_W*NUM_VOICES-1:0]  voice_vel,
  output logic [NUM_VOICES-1:0]        voice_repeat,
  output logic                         voice_steal,
  input  logic                         sustain
);

  localparam int IDX_W = vidx_w(NUM_VOICES);

  state_e              state_q;
  logic                ready_q;
  logic [IDX_W-1:0]    idx_q;
  logic [NOTE_W-1:0]   note_q;
  logic [VEL_W-1:0]    vel_q;
  logic                off_q;
  logic                m_hit_q, m_hit_d, f_hit_q, f_hit_d, o_hit_q, o_hit_d;
  logic [IDX_W-1:0]    m_idx_q, m_idx_d, f_idx_q, f_idx_d, o_idx_q, o_idx_d;
  logic [AGE_W-1:0]    o_age_q, o_age_d;
  logic [NUM_VOICES-1:0] load_q, vupd_q, aclr_q, ainc_q, rpt_q, rel_q, sset_q, srel_q;
  logic                steal_stb_q, steal_q;
  logic [IDX_W-1:0]    alloc_idx;
  logic [NUM_VOICES-1:0] alloc_oh;
  logic [NOTE_W-1:0]   note_w [NUM_VOICES];
  logic [AGE_W-1:0]    age_w  [NUM_VOICES];

`ifdef VOICE_SUSTAIN_EN
  logic sus_q, pend_q;
`else
  logic unused_sustain;
  assign unused_sustain = sustain;
`endif

  // Scan comparators for the voice currently addressed by idx_q.
  always_comb begin
    m_hit_d = m_hit_q;  m_idx_d = m_idx_q;
    f_hit_d = f_hit_q;  f_idx_d = f_idx_q;
    o_hit_d = o_hit_q;  o_idx_d = o_idx_q;  o_age_d = o_age_q;
    if (voice_note_on[idx_q] && (note_w[idx_q] == note_q) && !m_hit_q) begin
      m_hit_d = 1'b1;  m_idx_d = idx_q;
    end
    if (!voice_note_on[idx_q] && !f_hit_q) begin
      f_hit_d = 1'b1;  f_idx_d = idx_q;
    end
    if (voice_note_on[idx_q] && (!o_hit_q || (age_w[idx_q] > o_age_q))) begin
      o_hit_d = 1'b1;  o_idx_d = idx_q;  o_age_d = age_w[idx_q];
    end
  end

  always_comb begin
    alloc_idx = o_idx_q;
    if (m_hit_q) alloc_idx = m_idx_q;
    else if (f_hit_q) alloc_idx = f_idx_q;
    alloc_oh = '0;
    alloc_oh[alloc_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;  ready_q <= 1'b0;  idx_q <= '0;
      note_q  <= '0;    vel_q   <= '0;    off_q <= 1'b0;
      m_hit_q <= 1'b0;  m_idx_q <= '0;    f_hit_q <= 1'b0;  f_idx_q <= '0;
      o_hit_q <= 1'b0;  o_idx_q <= '0;    o_age_q <= '0;
      load_q <= '0;  vupd_q <= '0;  aclr_q <= '0;  ainc_q <= '0;
      rpt_q  <= '0;  rel_q  <= '0;  sset_q <= '0;  srel_q <= '0;
      steal_stb_q <= 1'b0;  steal_q <= 1'b0;
`ifdef VOICE_SUSTAIN_EN
      sus_q <= 1'b0;  pend_q <= 1'b0;
`endif
    end else begin
      load_q <= '0;  vupd_q <= '0;  aclr_q <= '0;  ainc_q <= '0;
      rpt_q  <= '0;  rel_q  <= '0;  sset_q <= '0;  srel_q <= '0;
      steal_stb_q <= 1'b0;
      steal_q     <= steal_stb_q;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (ev_valid && ready_q) begin
            state_q <= SCAN;  ready_q <= 1'b0;  idx_q <= '0;
            note_q  <= ev_note;  vel_q <= ev_vel;
            off_q   <= !ev_note_on || (ev_vel == '0);
            m_hit_q <= 1'b0;  m_idx_q <= '0;  f_hit_q <= 1'b0;  f_idx_q <= '0;
            o_hit_q <= 1'b0;  o_idx_q <= '0;  o_age_q <= '0;
          end
`ifdef VOICE_SUSTAIN_EN
          else if (pend_q) begin
            state_q <= RELEASE;  ready_q <= 1'b0;
            srel_q  <= '1;       pend_q  <= 1'b0;
          end
`endif
        end
        SCAN: begin
          m_hit_q <= m_hit_d;  m_idx_q <= m_idx_d;
          f_hit_q <= f_hit_d;  f_idx_q <= f_idx_d;
          o_hit_q <= o_hit_d;  o_idx_q <= o_idx_d;  o_age_q <= o_age_d;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IDX_W'(NUM_VOICES - 1)) state_q <= COMMIT;
        end
        COMMIT: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          if (!off_q) begin
            aclr_q <= alloc_oh;
            ainc_q <= ~alloc_oh;
            if (m_hit_q) begin
              vupd_q <= alloc_oh;  rpt_q <= alloc_oh;
            end else if (f_hit_q) begin
              load_q <= alloc_oh;
            end else begin
              load_q <= alloc_oh;  rpt_q <= alloc_oh;  steal_stb_q <= 1'b1;
            end
          end else if (m_hit_q) begin
`ifdef VOICE_SUSTAIN_EN
            if (sustain) sset_q <= alloc_oh;
            else rel_q <= alloc_oh;
`else
            rel_q <= alloc_oh;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
`ifdef VOICE_SUSTAIN_EN
      sus_q <= sustain;
      if (sus_q && !sustain) pend_q <= 1'b1;
`endif
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot #(.AGE_W(AGE_W)) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_i    (load_q[i]),
      .vel_upd_i (vupd_q[i]),
      .age_clr_i (aclr_q[i]),
      .age_inc_i (ainc_q[i]),
      .rpt_i     (rpt_q[i]),
      .rel_i     (rel_q[i]),
      .sus_set_i (sset_q[i]),
      .sus_rel_i (srel_q[i]),
      .note_i    (note_q),
      .vel_i     (vel_q),
      .gate_o    (voice_note_on[i]),
      .note_o    (note_w[i]),
      .vel_o     (voice_vel[VEL_W*i +: VEL_W]),
      .age_o     (age_w[i]),
      .rpt_o     (voice_repeat[i])
    );
    assign voice_note[NOTE_W*i +: NOTE_W] = note_w[i];
  end

  assign ev_ready    = ready_q;
  assign voice_steal = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with four voices; each task checks its own scenario.
module tb_voice_allocator;

  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ev_valid = 1'b0;
  logic          ev_ready;
  logic          ev_note_on = 1'b0;
  logic [6:0]    ev_note = '0;
  logic [6:0]    ev_vel = '0;
  logic [NV-1:0] voice_note_on;
  logic [7*NV-1:0] voice_note;
  logic [7*NV-1:0] voice_vel;
  logic [NV-1:0] voice_repeat;
  logic          voice_steal;
  logic          sustain = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_note_on    (ev_note_on),
    .ev_note       (ev_note),
    .ev_vel        (ev_vel),
    .voice_note_on (voice_note_on),
    .voice_note    (voice_note),
    .voice_vel     (voice_vel),
    .voice_repeat  (voice_repeat),
    .voice_steal   (voice_steal),
    .sustain       (sustain)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] vnote(input int i);
    return voice_note[7*i +: 7];
  endfunction

  function automatic logic [6:0] vvel(input int i);
    return voice_vel[7*i +: 7];
  endfunction

  // Returns one time unit after the accepting edge.
  task automatic send_nowait(input logic on, input logic [6:0] n, input logic [6:0] v);
    int w = 0;
    @(negedge clk);
    while (!ev_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ev_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_ready_timeout: ev_ready=%b required 1", ev_ready);
    end
    ev_valid = 1'b1; ev_note_on = on; ev_note = n; ev_vel = v;
    @(posedge clk); #1;
    ev_valid = 1'b0;
  endtask

  // Returns one time unit after the edge where results become visible.
  task automatic send(input logic on, input logic [6:0] n, input logic [6:0] v);
    send_nowait(on, n, v);
    repeat (NV + 2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({ev_ready, voice_note_on, voice_repeat, voice_steal} !== '0) begin
      n_err++;
      $display("FAIL reset_ctl: ready=%b gate=%b rpt=%b steal=%b required all 0",
               ev_ready, voice_note_on, voice_repeat, voice_steal);
    end
    n_vec++;
    if ({voice_note, voice_vel} !== '0) begin
      n_err++;
      $display("FAIL reset_data: note=%h vel=%h required 0", voice_note, voice_vel);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (ev_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready_after_release: ready=%b required 1", ev_ready);
    end
  endtask

  task automatic test_first_alloc();
    send_nowait(1'b1, 7'd60, 7'd100);
    repeat (NV + 1) @(posedge clk); #1;
    n_vec++;
    if ({voice_note_on, ev_ready} !== 5'b0000_0) begin
      n_err++;
      $display("FAIL first_early: gate=%b ready=%b required 0000 0", voice_note_on, ev_ready);
    end
    @(posedge clk); #1;
    n_vec++;
    if (voice_note_on !== 4'b0001 || vnote(0) !== 7'd60 || vvel(0) !== 7'd100 || ev_ready !== 1'b1) begin
      n_err++;
      $display("FAIL first_alloc: gate=%b note0=%0d vel0=%0d ready=%b required 0001 60 100 1",
               voice_note_on, vnote(0), vvel(0), ev_ready);
    end
  endtask

  task automatic test_steal();
    send(1'b1, 7'd62, 7'd80);
    send(1'b1, 7'd64, 7'd81);
    send(1'b1, 7'd67, 7'd82);
    n_vec++;
    if (voice_note_on !== 4'b1111 || vnote(1) !== 7'd62 || vnote(2) !== 7'd64 || vnote(3) !== 7'd67) begin
      n_err++;
      $display("FAIL fill_voices: gate=%b notes=%0d,%0d,%0d required 1111 62,64,67",
               voice_note_on, vnote(1), vnote(2), vnote(3));
    end
    send(1'b1, 7'd69, 7'd90);
    n_vec++;
    if (vnote(0) !== 7'd69 || vvel(0) !== 7'd90 || voice_repeat !== 4'b0001 || voice_steal !== 1'b1
        || voice_note_on !== 4'b1111) begin
      n_err++;
      $display("FAIL steal_oldest: note0=%0d vel0=%0d rpt=%b steal=%b gate=%b required 69 90 0001 1 1111",
               vnote(0), vvel(0), voice_repeat, voice_steal, voice_note_on);
    end
    @(posedge clk); #1;
    n_vec++;
    if (voice_repeat !== 4'b0000 || voice_steal !== 1'b0) begin
      n_err++;
      $display("FAIL steal_pulse_width: rpt=%b steal=%b required 0000 0", voice_repeat, voice_steal);
    end
  endtask

  task automatic test_retrigger();
    send(1'b1, 7'd62, 7'd40);
    n_vec++;
    if (vvel(1) !== 7'd40 || voice_repeat !== 4'b0010 || voice_steal !== 1'b0 || vnote(1) !== 7'd62) begin
      n_err++;
      $display("FAIL retrigger: vel1=%0d rpt=%b steal=%b note1=%0d required 40 0010 0 62",
               vvel(1), voice_repeat, voice_steal, vnote(1));
    end
    @(posedge clk); #1;
    n_vec++;
    if (voice_repeat !== 4'b0000) begin
      n_err++; $display("FAIL retrigger_pulse_width: rpt=%b required 0000", voice_repeat);
    end
  endtask

  task automatic test_release();
    send(1'b0, 7'd64, 7'd0);
    n_vec++;
    if (voice_note_on !== 4'b1011 || vnote(2) !== 7'd64) begin
      n_err++;
      $display("FAIL note_off: gate=%b note2=%0d required 1011 64", voice_note_on, vnote(2));
    end
    send(1'b1, 7'd72, 7'd90);
    n_vec++;
    if (voice_note_on !== 4'b1111 || vnote(2) !== 7'd72 || vvel(2) !== 7'd90 || voice_steal !== 1'b0) begin
      n_err++;
      $display("FAIL first_free: gate=%b note2=%0d vel2=%0d steal=%b required 1111 72 90 0",
               voice_note_on, vnote(2), vvel(2), voice_steal);
    end
    send(1'b1, 7'd72, 7'd0);
    n_vec++;
    if (voice_note_on !== 4'b1011 || voice_repeat !== 4'b0000 || vnote(2) !== 7'd72) begin
      n_err++;
      $display("FAIL vel0_off: gate=%b rpt=%b note2=%0d required 1011 0000 72",
               voice_note_on, voice_repeat, vnote(2));
    end
    send(1'b0, 7'd50, 7'd0);
    n_vec++;
    if (voice_note_on !== 4'b1011 || vnote(0) !== 7'd69 || vnote(1) !== 7'd62 || vnote(3) !== 7'd67
        || ev_ready !== 1'b1) begin
      n_err++;
      $display("FAIL unheld_off: gate=%b notes=%0d,%0d,%0d ready=%b required 1011 69,62,67 1",
               voice_note_on, vnote(0), vnote(1), vnote(3), ev_ready);
    end
  endtask

  task automatic test_reset_mid_scan();
    send_nowait(1'b1, 7'd30, 7'd30);
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({ev_ready, voice_note_on, voice_repeat, voice_steal, voice_note, voice_vel} !== '0) begin
      n_err++;
      $display("FAIL mid_scan_reset: ready=%b gate=%b note=%h vel=%h required all 0",
               ev_ready, voice_note_on, voice_note, voice_vel);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (ev_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_scan_ready: ready=%b required 1", ev_ready);
    end
    send(1'b1, 7'd33, 7'd44);
    n_vec++;
    if (voice_note_on !== 4'b0001 || vnote(0) !== 7'd33) begin
      n_err++;
      $display("FAIL mid_scan_after: gate=%b note0=%0d required 0001 33", voice_note_on, vnote(0));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd40; ev_vel = 7'd10;
    @(posedge clk); #1;
    ev_note = 7'd41; ev_vel = 7'd11;
    repeat (NV + 2) @(posedge clk); #1;
    n_vec++;
    if (voice_note_on !== 4'b0001 || vnote(0) !== 7'd40) begin
      n_err++;
      $display("FAIL b2b_first: gate=%b note0=%0d required 0001 40", voice_note_on, vnote(0));
    end
    repeat (NV + 3) @(posedge clk); #1;
    ev_valid = 1'b0;
    n_vec++;
    if (voice_note_on !== 4'b0011 || vnote(1) !== 7'd41 || vvel(1) !== 7'd11) begin
      n_err++;
      $display("FAIL b2b_second: gate=%b note1=%0d vel1=%0d required 0011 41 11",
               voice_note_on, vnote(1), vvel(1));
    end
  endtask

  task automatic test_age_saturation();
    do_reset();
    send(1'b1, 7'd10, 7'd1);
    send(1'b1, 7'd11, 7'd1);
    send(1'b1, 7'd12, 7'd1);
    send(1'b1, 7'd13, 7'd1);
    for (int k = 0; k < 253; k++) send(1'b1, 7'd12, 7'd2);
    send(1'b1, 7'd20, 7'd5);
    n_vec++;
    if (vnote(0) !== 7'd20 || vnote(1) !== 7'd11 || voice_repeat !== 4'b0001 || voice_steal !== 1'b1) begin
      n_err++;
      $display("FAIL age_saturate_tie: notes=%0d,%0d rpt=%b steal=%b required 20,11 0001 1",
               vnote(0), vnote(1), voice_repeat, voice_steal);
    end
  endtask

  task automatic test_sustain();
    int w = 0;
    do_reset();
    send(1'b1, 7'd60, 7'd100);
    @(negedge clk);
    sustain = 1'b1;
    send(1'b0, 7'd60, 7'd0);
`ifdef VOICE_SUSTAIN_EN
    n_vec++;
    if (voice_note_on !== 4'b0001) begin
      n_err++; $display("FAIL sustain_hold: gate=%b required 0001", voice_note_on);
    end
    @(negedge clk);
    sustain = 1'b0;
    while (voice_note_on !== 4'b0000 && w < 8) begin
      @(posedge clk); #1;
      w++;
    end
    n_vec++;
    if (voice_note_on !== 4'b0000) begin
      n_err++; $display("FAIL sustain_release: gate=%b required 0000", voice_note_on);
    end
    repeat (2) @(posedge clk); #1;
    n_vec++;
    if (ev_ready !== 1'b1) begin
      n_err++; $display("FAIL sustain_ready: ready=%b required 1", ev_ready);
    end
`else
    n_vec++;
    if (voice_note_on !== 4'b0000) begin
      n_err++; $display("FAIL sustain_ignored: gate=%b required 0000", voice_note_on);
    end
    sustain = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_first_alloc();
    test_steal();
    test_retrigger();
    test_release();
    test_reset_mid_scan();
    test_back_to_back();
    test_sustain();
    test_age_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
